bin_to_bcd_seq: RTL and testbench
=================================

// Module: bin_to_bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
//  Sits upstream of the decimal display/print stage: it accepts an unsigned binary word and
//  emits packed BCD digits, most significant digit in the top nibble.
//  Valid/ready handshake on both sides; one conversion in flight at a time.
// PARAMETERS
//  BIN_W   8  width of the binary input word (legal 4..16)
//  DIGITS  3  number of BCD output digits; must satisfy 10**DIGITS > 2**BIN_W - 1
// PORTS
//  clk        in   1           single clock; all state updates on the rising edge
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           bin_in is valid
//  in_ready   out  1           block can accept a new word (IDLE only)
//  bin_in     in   BIN_W       unsigned binary operand
//  out_valid  out  1           bcd_out holds a finished result
//  out_ready  in   1           consumer accepts bcd_out
//  bcd_out    out  4*DIGITS    packed BCD; digit k in bits [4k+3:4k], k=0 is the units digit
//  busy       out  1           high while in SHIFT
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state=IDLE, bcd_out=0, out_valid=0, in_ready=1, busy=0,
//    internal shift/count regs cleared. Reset wins over every other event, including mid-SHIFT
//    (conversion aborted, no output produced) and DONE (result discarded).
//  - FSM IDLE -> SHIFT -> DONE -> IDLE.
//    IDLE: in_ready=1. On an edge with in_valid=1: load bin reg=bin_in, bcd accumulator=0,
//      bit counter=BIN_W, and go to SHIFT.
//    SHIFT: in_ready=0, busy=1. On each edge, every BCD digit >=5 gets +3 (4-bit, no carry out
//      of the digit). Then {acc,bin} shifts left by 1 and the counter decrements.
//      When the counter reaches 0 (the BIN_W-th shift edge), latch the accumulator into
//      bcd_out and go to DONE.
//    DONE: out_valid=1, and bcd_out is stable while out_valid=1 && out_ready=0.
//      On an edge with out_ready=1, go to IDLE and clear out_valid. bcd_out holds its last value.
//  - Latency: out_valid rises exactly BIN_W clocks after the accepting edge.
//    Throughput: one result per BIN_W+2 clocks at best; there is no overlap of input and output.
//  - in_valid while not IDLE: ignored; the producer must hold it until in_ready.
//  - Arithmetic: the accumulator is exactly 4*DIGITS bits. Bits shifted beyond the MSB are
//    dropped; the DIGITS rule guarantees this never loses data. Input 0 gives bcd_out=0.
//  - If out_ready=1 already on the DONE entry edge, that has no effect; the handshake happens
//    at the first edge in DONE.
// CONFIGURATION
//  `BCD_BLANK_EN defined: adds output blank_n [DIGITS-1:0], registered alongside bcd_out.
//    blank_n[k]=0 when digit k and all higher digits are zero (leading-zero blanking).
//    blank_n[0] is always 1, so value 0 shows "0". Reset value is all 1s.
//  Not defined: no blank_n port, and no blanking logic is built.
// STRUCTURE
//  Package bcd_pkg holds:
//    - the state encoding typedef (IDLE/SHIFT/DONE, 2-bit)
//    - localparam BCD_ADJ_THRESH=4'd5 and BCD_ADJ_ADD=4'd3
//    - function bcd_digits_min(bin_w) for an elaboration-time check of DIGITS
//  Sub-module bcd_digit_adj: one combinational 4-bit digit (d>=5 ? d+3 : d).
//    Instantiated DIGITS times in a generate loop. The FSM, counter and registers stay in the top.
// TESTING
//  1. rst 2 cycles; bin_in=8'd11, in_valid 1 cycle -> out_valid after 8 clks, bcd_out=12'h011.
//  2. bin_in=8'd255, then 8'd0, then 8'd100, out_ready tied 1 -> 12'h255, 12'h000, 12'h100 in order.
//  3. Backpressure: bin_in=8'd42, out_ready=0 for 5 cycles in DONE -> bcd_out=12'h042 stable,
//     in_ready=0 throughout. Then out_ready=1 -> IDLE next cycle.
//  4. in_valid pulsed with 8'd99 during SHIFT of 8'd37 -> only 12'h037 is produced; 99 is dropped.
//  5. rst asserted at SHIFT cycle 4 of 8'd200 -> next cycle IDLE, out_valid=0, bcd_out=0,
//     and no result is ever emitted.
//  6. `BCD_BLANK_EN: 8'd7 -> blank_n=3'b001; 8'd0 -> 3'b001; 8'd105 -> 3'b111.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter: FSM encoding,
// double-dabble adjust constants and the elaboration-time digit-count helper.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [3:0] BCD_ADJ_THRESH = 4'd5;
   localparam logic [3:0] BCD_ADJ_ADD    = 4'd3;

   // Decimal digits needed to represent the largest unsigned value of bin_w bits.
   function automatic int bcd_digits_min(input int bin_w);
      longint v;
      int     d;
      v = (longint'(1) << bin_w) - 1;
      d = 1;
      for (int i = 0; i < 20; i++) begin
         if (v >= 10) begin
            v = v / 10;
            d = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: a digit of 5 or more gets +3 before the shift,
// wrapping inside 4 bits so nothing carries into the next digit.
module bcd_digit_adj
   import bcd_pkg::*;
(
   input  logic [3:0] i_digit,
   output logic [3:0] o_digit
);

   assign o_digit = (i_digit >= BCD_ADJ_THRESH) ? i_digit + BCD_ADJ_ADD : i_digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock,
// valid/ready on both sides. Optional leading-zero blanking output under `BCD_BLANK_EN.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [BIN_W-1:0]      bin_in,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  busy
`ifdef BCD_BLANK_EN
   ,
   output logic [DIGITS-1:0]     blank_n
`endif
);

   localparam int ACC_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   if (BIN_W < 4 || BIN_W > 16) begin : g_bad_bin_w
      $error("bin_to_bcd_seq: BIN_W must lie in 4..16");
   end
   if (DIGITS < bcd_digits_min(BIN_W)) begin : g_bad_digits
      $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
   end

   state_t             r_state;
   state_t             w_state_nxt;
   logic [BIN_W-1:0]   r_bin;
   logic [ACC_W-1:0]   r_acc;
   logic [CNT_W-1:0]   r_cnt;
   logic [ACC_W-1:0]   r_bcd;
   logic [ACC_W-1:0]   w_adj;
   logic [ACC_W-1:0]   w_acc_nxt;
   logic               w_last;

   for (genvar k = 0; k < DIGITS; k++) begin : g_adj
      bcd_digit_adj u_adj (
         .i_digit (r_acc[4*k +: 4]),
         .o_digit (w_adj[4*k +: 4])
      );
   end

   // Adjusted accumulator shifted left with the next binary bit entering at the LSB;
   // the top bit falls off, which the DIGITS rule makes harmless.
   assign w_acc_nxt = (w_adj << 1) | {{(ACC_W-1){1'b0}}, r_bin[BIN_W-1]};
   assign w_last    = (r_cnt == CNT_W'(1));

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      // NOTE: default first so no path leaves the next state unassigned (no latch).
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid)  w_state_nxt = SHIFT;
         SHIFT:   if (w_last)    w_state_nxt = DONE;
         DONE:    if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_bin <= '0;
         r_acc <= '0;
         r_cnt <= '0;
         r_bcd <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_bin <= bin_in;
                  r_acc <= '0;
                  r_cnt <= CNT_W'(BIN_W);
               end
            end
            SHIFT: begin
               r_acc <= w_acc_nxt;
               r_bin <= r_bin << 1;
               r_cnt <= r_cnt - CNT_W'(1);
               if (w_last) r_bcd <= w_acc_nxt;
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (r_state == IDLE);
   assign busy      = (r_state == SHIFT);
   assign out_valid = (r_state == DONE);
   assign bcd_out   = r_bcd;

`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0] r_blank_n;
   logic [DIGITS-1:0] w_blank_nxt;

   // A digit is shown once it or any higher digit is non-zero; units always shown.
   always_comb begin
      logic v_any;
      v_any       = 1'b0;
      w_blank_nxt = '0;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         v_any          = v_any | (|w_acc_nxt[4*k +: 4]);
         w_blank_nxt[k] = v_any;
      end
      w_blank_nxt[0] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst)                                r_blank_n <= '1;
      else if ((r_state == SHIFT) && w_last)  r_blank_n <= w_blank_nxt;
   end

   assign blank_n = r_blank_n;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed self-checking bench for bin_to_bcd_seq (BIN_W=8, DIGITS=3).
// Define BCD_BLANK_EN to also exercise the leading-zero blanking output.
module tb_bin_to_bcd_seq;

   localparam int BIN_W  = 8;
   localparam int DIGITS = 3;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 in_valid;
   logic                 in_ready;
   logic [BIN_W-1:0]     bin_in;
   logic                 out_valid;
   logic                 out_ready;
   logic [4*DIGITS-1:0]  bcd_out;
   logic                 busy;
`ifdef BCD_BLANK_EN
   logic [DIGITS-1:0]    blank_n;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_in    (bin_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd_out   (bcd_out),
      .busy      (busy)
`ifdef BCD_BLANK_EN
      ,
      .blank_n   (blank_n)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one word, return the clocks from the accepting edge to out_valid.
   task automatic convert(input logic [BIN_W-1:0] v, output int lat);
      int w;
      w = 0;
      while (!in_ready && w < 50) begin
         tick();
         w++;
      end
      check("in_ready_wait", {31'd0, in_ready}, 32'd1);
      bin_in   = v;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   int lat;
   int ov_seen;
   logic [BIN_W-1:0]    vec_in  [4] = '{8'd9, 8'd10, 8'd128, 8'd99};
   logic [4*DIGITS-1:0] vec_exp [4] = '{12'h009, 12'h010, 12'h128, 12'h099};

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      bin_in    = '0;
      out_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      check("rst_in_ready",  {31'd0, in_ready},  32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_busy",      {31'd0, busy},      32'd0);
      check("rst_bcd",       {20'd0, bcd_out},   32'h000);
`ifdef BCD_BLANK_EN
      check("rst_blank_n",   {29'd0, blank_n},   32'b111);
`endif

      // 1. Single conversion with exact latency
      bin_in   = 8'd11;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      check("t1_busy",     {31'd0, busy},     32'd1);
      check("t1_in_ready", {31'd0, in_ready}, 32'd0);
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("t1_latency", lat, 32'd8);
      check("t1_bcd",     {20'd0, bcd_out}, 32'h011);
      out_ready = 1'b1;
      tick();
      check("t1_back_idle", {31'd0, in_ready}, 32'd1);

      // 2. Back-to-back with out_ready tied high
      convert(8'd255, lat);
      check("t2_lat_255", lat, 32'd8);
      check("t2_bcd_255", {20'd0, bcd_out}, 32'h255);
      convert(8'd0, lat);
      check("t2_bcd_0",   {20'd0, bcd_out}, 32'h000);
      convert(8'd100, lat);
      check("t2_bcd_100", {20'd0, bcd_out}, 32'h100);
      tick();
      check("t2_ov_clear", {31'd0, out_valid}, 32'd0);
      check("t2_bcd_hold", {20'd0, bcd_out},   32'h100);

      for (int i = 0; i < 4; i++) begin
         convert(vec_in[i], lat);
         check($sformatf("tbl_bcd_%0d", vec_in[i]), {20'd0, bcd_out}, {20'd0, vec_exp[i]});
      end
      tick();

      // 3. Backpressure in DONE
      out_ready = 1'b0;
      convert(8'd42, lat);
      check("t3_lat", lat, 32'd8);
      for (int i = 0; i < 5; i++) begin
         check("t3_bcd_stable", {20'd0, bcd_out},   32'h042);
         check("t3_in_ready",   {31'd0, in_ready},  32'd0);
         check("t3_out_valid",  {31'd0, out_valid}, 32'd1);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("t3_idle",     {31'd0, in_ready},  32'd1);
      check("t3_ov_clear", {31'd0, out_valid}, 32'd0);

      // 4. in_valid during SHIFT is ignored
      out_ready = 1'b0;
      bin_in    = 8'd37;
      in_valid  = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      bin_in   = 8'd99;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 3;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("t4_lat", lat, 32'd8);
      check("t4_bcd", {20'd0, bcd_out}, 32'h037);
      out_ready = 1'b1;
      tick();
      ov_seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (out_valid || busy) ov_seen++;
         tick();
      end
      check("t4_no_second", ov_seen, 32'd0);
      check("t4_bcd_hold",  {20'd0, bcd_out}, 32'h037);

      // 5. Reset mid-SHIFT aborts the conversion
      bin_in   = 8'd200;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_in_ready",  {31'd0, in_ready},  32'd1);
      check("t5_busy",      {31'd0, busy},      32'd0);
      check("t5_out_valid", {31'd0, out_valid}, 32'd0);
      check("t5_bcd",       {20'd0, bcd_out},   32'h000);
      ov_seen = 0;
      for (int i = 0; i < 15; i++) begin
         if (out_valid) ov_seen++;
         tick();
      end
      check("t5_no_result", ov_seen, 32'd0);

`ifdef BCD_BLANK_EN
      // 6. Leading-zero blanking
      convert(8'd7, lat);
      check("t6_bcd_7",    {20'd0, bcd_out}, 32'h007);
      check("t6_blank_7",  {29'd0, blank_n}, 32'b001);
      convert(8'd0, lat);
      check("t6_blank_0",  {29'd0, blank_n}, 32'b001);
      convert(8'd105, lat);
      check("t6_bcd_105",  {20'd0, bcd_out}, 32'h105);
      check("t6_blank_105",{29'd0, blank_n}, 32'b111);
      convert(8'd42, lat);
      check("t6_blank_42", {29'd0, blank_n}, 32'b011);
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
